// File: rtl/osnt_sume_ts_pkg.sv
// Shared definitions for the TUSER timestamper: FSM encoding, default widths and
// a TKEEP popcount helper.
package osnt_sume_ts_pkg;

    localparam int unsigned DefTdataWidth = 256;
    localparam int unsigned DefTuserWidth = 128;
    localparam int unsigned DefTsWidth    = 64;
    localparam int unsigned DefTsOffset   = 64;
    localparam int unsigned MaxKeepWidth  = 64;

    typedef enum logic {
        StSop,
        StMid
    } ts_state_e;

    // Callers zero-extend narrower TKEEP vectors to MaxKeepWidth.
    function automatic logic [7:0] keep_popcount(input logic [MaxKeepWidth-1:0] keep);
        logic [7:0] cnt;
        cnt = '0;
        for (int i = 0; i < MaxKeepWidth; i++) begin
            cnt = cnt + {7'd0, keep[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/osnt_sume_axis_skid.sv
// Two-entry registered skid buffer: an output register plus one spill entry.
// Upstream ready comes straight from a flop and drops only when both entries hold data.
module osnt_sume_axis_skid #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] s_data_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    output logic [Width-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i
);

    logic [Width-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [Width-1:0] skid_data_q, skid_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic             ready_q, ready_d;
    logic             s_acc;

    always_comb begin
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        s_acc        = s_valid_i & ready_q;

        if (!out_valid_q || m_ready_i) begin
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = s_acc;
                if (s_acc) begin
                    out_data_d = s_data_i;
                end
            end
        end else if (s_acc) begin
            skid_valid_d = 1'b1;
            skid_data_d  = s_data_i;
        end

        // Spill entry full implies output register full as well.
        ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
        end
    end

    assign s_ready_o = ready_q;
    assign m_data_o  = out_data_q;
    assign m_valid_o = out_valid_q;

endmodule

// File: rtl/osnt_sume_tuser_timestamper.sv
// Stamps a free-running timestamp into first-beat TUSER and keeps packet/byte stats.
// Define OSNT_TS_BYTE_COUNT_EN to build the byte accumulator and STAT_BYTE_COUNT.
module osnt_sume_tuser_timestamper
    import osnt_sume_ts_pkg::*;
#(
    parameter int unsigned C_AXIS_TDATA_WIDTH = DefTdataWidth,
    parameter int unsigned C_AXIS_TUSER_WIDTH = DefTuserWidth,
    parameter int unsigned C_TS_WIDTH         = DefTsWidth,
    parameter int unsigned C_TS_OFFSET        = DefTsOffset
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TKEEP,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
    input  logic                            S_AXIS_TLAST,
    input  logic                            S_AXIS_TVALID,
    output logic                            S_AXIS_TREADY,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TKEEP,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
    output logic                            M_AXIS_TLAST,
    output logic                            M_AXIS_TVALID,
    input  logic                            M_AXIS_TREADY,
    input  logic [31:0]                     TS_STEP,
    input  logic                            TS_LOAD,
    input  logic [C_TS_WIDTH-1:0]           TS_LOAD_VALUE,
    output logic [31:0]                     STAT_PKT_COUNT,
    output logic [63:0]                     STAT_BYTE_COUNT
);

    localparam int unsigned KeepWidth = C_AXIS_TDATA_WIDTH / 8;
    localparam int unsigned SkidWidth = C_AXIS_TDATA_WIDTH + KeepWidth + C_AXIS_TUSER_WIDTH + 1;

    ts_state_e                     state_q, state_d;
    logic [C_TS_WIDTH-1:0]         ts_q, ts_d;
    logic [31:0]                   pkt_cnt_q, pkt_cnt_d;
    logic [C_AXIS_TUSER_WIDTH-1:0] tuser_stamped;
    logic                          accept;
    logic [SkidWidth-1:0]          skid_out;

    assign accept = S_AXIS_TVALID & S_AXIS_TREADY;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StSop:   if (accept && !S_AXIS_TLAST) state_d = StMid;
            StMid:   if (accept && S_AXIS_TLAST)  state_d = StSop;
            default: state_d = StSop;
        endcase
    end

    // The stamp uses ts_q, i.e. the value before this edge's load/step.
    always_comb begin
        tuser_stamped = S_AXIS_TUSER;
        if (state_q == StSop) begin
            tuser_stamped[C_TS_OFFSET +: C_TS_WIDTH] = ts_q;
        end
    end

    always_comb begin
        ts_d      = TS_LOAD ? TS_LOAD_VALUE : ts_q + C_TS_WIDTH'(TS_STEP);
        pkt_cnt_d = pkt_cnt_q;
        if (accept && S_AXIS_TLAST) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= StSop;
            ts_q      <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ts_q      <= ts_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign STAT_PKT_COUNT = pkt_cnt_q;

`ifdef OSNT_TS_BYTE_COUNT_EN
    logic [63:0]             byte_acc_q, byte_acc_d;
    logic [63:0]             byte_cnt_q, byte_cnt_d;
    logic [63:0]             beat_bytes;
    logic [MaxKeepWidth-1:0] keep_ext;

    always_comb begin
        keep_ext                  = '0;
        keep_ext[KeepWidth-1:0]   = S_AXIS_TKEEP;
        beat_bytes                = 64'(keep_popcount(keep_ext));
        byte_acc_d                = byte_acc_q;
        byte_cnt_d                = byte_cnt_q;
        if (accept) begin
            if (S_AXIS_TLAST) begin
                byte_cnt_d = byte_cnt_q + byte_acc_q + beat_bytes;
                byte_acc_d = '0;
            end else begin
                byte_acc_d = byte_acc_q + beat_bytes;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            byte_acc_q <= '0;
            byte_cnt_q <= '0;
        end else begin
            byte_acc_q <= byte_acc_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign STAT_BYTE_COUNT = byte_cnt_q;
`else
    assign STAT_BYTE_COUNT = '0;
`endif

    osnt_sume_axis_skid #(
        .Width(SkidWidth)
    ) u_skid (
        .clk_i    (ACLK),
        .rst_ni   (ARESETN),
        .s_data_i ({S_AXIS_TDATA, S_AXIS_TKEEP, tuser_stamped, S_AXIS_TLAST}),
        .s_valid_i(S_AXIS_TVALID),
        .s_ready_o(S_AXIS_TREADY),
        .m_data_o (skid_out),
        .m_valid_o(M_AXIS_TVALID),
        .m_ready_i(M_AXIS_TREADY)
    );

    assign {M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TUSER, M_AXIS_TLAST} = skid_out;

endmodule

// File: tb/tb_osnt_sume_tuser_timestamper.sv
// Directed and back-pressure bench for osnt_sume_tuser_timestamper.
module tb_osnt_sume_tuser_timestamper;

    localparam int W    = 256;
    localparam int K    = 32;
    localparam int U    = 128;
    localparam int OutW = 2 + K + U + W;
`ifdef OSNT_TS_BYTE_COUNT_EN
    localparam bit ByteEn = 1'b1;
`else
    localparam bit ByteEn = 1'b0;
`endif

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [W-1:0]  s_tdata, m_tdata;
    logic [K-1:0]  s_tkeep, m_tkeep;
    logic [U-1:0]  s_tuser, m_tuser;
    logic          s_tlast, s_tvalid, s_tready;
    logic          m_tlast, m_tvalid, m_tready;
    logic [31:0]   ts_step;
    logic          ts_load;
    logic [63:0]   ts_load_value;
    logic [31:0]   stat_pkt;
    logic [63:0]   stat_byte;
    logic [63:0]   ts_model;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] data;
        logic [K-1:0] keep;
        logic [U-1:0] user;
        logic         last;
    } beat_t;

    beat_t exp_q[$];

    always #5 aclk = ~aclk;

    osnt_sume_tuser_timestamper dut (
        .ACLK           (aclk),
        .ARESETN        (aresetn),
        .S_AXIS_TDATA   (s_tdata),
        .S_AXIS_TKEEP   (s_tkeep),
        .S_AXIS_TUSER   (s_tuser),
        .S_AXIS_TLAST   (s_tlast),
        .S_AXIS_TVALID  (s_tvalid),
        .S_AXIS_TREADY  (s_tready),
        .M_AXIS_TDATA   (m_tdata),
        .M_AXIS_TKEEP   (m_tkeep),
        .M_AXIS_TUSER   (m_tuser),
        .M_AXIS_TLAST   (m_tlast),
        .M_AXIS_TVALID  (m_tvalid),
        .M_AXIS_TREADY  (m_tready),
        .TS_STEP        (ts_step),
        .TS_LOAD        (ts_load),
        .TS_LOAD_VALUE  (ts_load_value),
        .STAT_PKT_COUNT (stat_pkt),
        .STAT_BYTE_COUNT(stat_byte)
    );

    // Reference free-running timestamp, used only for the randomised run.
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) ts_model <= '0;
        else if (ts_load) ts_model <= ts_load_value;
        else ts_model <= ts_model + 64'(ts_step);
    end

    function automatic logic [OutW-1:0] out_vec();
        return {m_tvalid, m_tlast, m_tkeep, m_tuser, m_tdata};
    endfunction

    task automatic cycle();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic drive(input logic [W-1:0] d, input logic [K-1:0] k, input logic [U-1:0] u,
                         input logic l);
        s_tdata  = d;
        s_tkeep  = k;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        idle();
        ts_load = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge aclk);
        checks++;
        if (out_vec() !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", out_vec());
        end
        checks++;
        if (s_tready !== 1'b0) begin
            failures++;
            $display("FAIL reset_tready: got %b expected 0", s_tready);
        end
        checks++;
        if (stat_pkt !== 32'd0 || stat_byte !== 64'd0) begin
            failures++;
            $display("FAIL reset_stats: got pkt=%0d bytes=%0d expected 0/0", stat_pkt, stat_byte);
        end
        aresetn = 1'b1;
        cycle();
        checks++;
        if (s_tready !== 1'b1) begin
            failures++;
            $display("FAIL release_tready: got %b expected 1", s_tready);
        end
    endtask

    task automatic test_three_beat();
        logic [W-1:0] d0, d1, d2;
        logic [U-1:0] u0, u1, u2;
        logic [OutW-1:0] exp;
        d0 = {8{32'h0A0B0C00}}; d1 = {8{32'h11112222}}; d2 = {8{32'h33334444}};
        u0 = {32'hAAAA0000, 32'hBBBB0000, 32'hCCCC0001, 32'hDDDD0001};
        u1 = {32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF0F0F0F0};
        u2 = {32'hCAFEBABE, 32'hDEADBEEF, 32'h01020304, 32'h05060708};
        apply_reset();
        m_tready      = 1'b1;
        ts_step       = 32'd1;
        ts_load       = 1'b1;
        ts_load_value = 64'h100;
        cycle();
        ts_load = 1'b0;
        checks++;
        if (m_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL tb3_idle_valid: got %b expected 0", m_tvalid);
        end
        drive(d0, 32'hFFFFFFFF, u0, 1'b0);
        cycle();
        exp = {1'b1, 1'b0, 32'hFFFFFFFF, 64'h100, u0[63:0], d0};
        checks++;
        if (out_vec() !== exp) begin
            failures++;
            $display("FAIL tb3_beat0: got %h expected %h", out_vec(), exp);
        end
        drive(d1, 32'hFFFFFFFF, u1, 1'b0);
        cycle();
        exp = {1'b1, 1'b0, 32'hFFFFFFFF, u1, d1};
        checks++;
        if (out_vec() !== exp) begin
            failures++;
            $display("FAIL tb3_beat1: got %h expected %h", out_vec(), exp);
        end
        drive(d2, 32'h0000FFFF, u2, 1'b1);
        cycle();
        exp = {1'b1, 1'b1, 32'h0000FFFF, u2, d2};
        checks++;
        if (out_vec() !== exp) begin
            failures++;
            $display("FAIL tb3_beat2: got %h expected %h", out_vec(), exp);
        end
        checks++;
        if (stat_pkt !== 32'd1 || stat_byte !== (ByteEn ? 64'd80 : 64'd0)) begin
            failures++;
            $display("FAIL tb3_stats: got pkt=%0d bytes=%0d expected 1/%0d", stat_pkt, stat_byte,
                     ByteEn ? 80 : 0);
        end
        idle();
        cycle();
        checks++;
        if (m_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL tb3_drain_valid: got %b expected 0", m_tvalid);
        end
    endtask

    task automatic test_back_to_back();
        logic [U-1:0] ua, ub, uc;
        logic [OutW-1:0] exp;
        ua = {32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
        ub = {32'h50505050, 32'h60606060, 32'h70707070, 32'h80808080};
        uc = {32'h99999999, 32'h88888888, 32'h77777777, 32'h66666666};
        apply_reset();
        m_tready      = 1'b1;
        ts_step       = 32'd1;
        ts_load       = 1'b1;
        ts_load_value = 64'h200;
        idle();
        cycle();
        ts_load = 1'b0;
        drive({8{32'hA5A5A5A5}}, 32'hFFFFFFFF, ua, 1'b1);
        cycle();
        exp = {1'b1, 1'b1, 32'hFFFFFFFF, 64'h200, ua[63:0], {8{32'hA5A5A5A5}}};
        checks++;
        if (out_vec() !== exp) begin
            failures++;
            $display("FAIL b2b_pkt_a: got %h expected %h", out_vec(), exp);
        end
        checks++;
        if (stat_pkt !== 32'd1) begin
            failures++;
            $display("FAIL b2b_pkt_count_a: got %0d expected 1", stat_pkt);
        end
        drive({8{32'h5A5A5A5A}}, 32'h0000000F, ub, 1'b1);
        cycle();
        exp = {1'b1, 1'b1, 32'h0000000F, 64'h201, ub[63:0], {8{32'h5A5A5A5A}}};
        checks++;
        if (out_vec() !== exp) begin
            failures++;
            $display("FAIL b2b_pkt_b: got %h expected %h", out_vec(), exp);
        end
        checks++;
        if (stat_pkt !== 32'd2 || stat_byte !== (ByteEn ? 64'd36 : 64'd0)) begin
            failures++;
            $display("FAIL b2b_stats: got pkt=%0d bytes=%0d expected 2/%0d", stat_pkt, stat_byte,
                     ByteEn ? 36 : 0);
        end
        drive({8{32'h0F0F0F0F}}, 32'h00000000, uc, 1'b1);
        cycle();
        exp = {1'b1, 1'b1, 32'h00000000, 64'h202, uc[63:0], {8{32'h0F0F0F0F}}};
        checks++;
        if (out_vec() !== exp) begin
            failures++;
            $display("FAIL b2b_pkt_c: got %h expected %h", out_vec(), exp);
        end
        checks++;
        if (stat_pkt !== 32'd3 || stat_byte !== (ByteEn ? 64'd36 : 64'd0)) begin
            failures++;
            $display("FAIL b2b_zero_keep: got pkt=%0d bytes=%0d expected 3/%0d", stat_pkt,
                     stat_byte, ByteEn ? 36 : 0);
        end
        idle();
        cycle();
    endtask

    task automatic test_ts_load();
        logic [U-1:0] ue, uf;
        ue = {32'h13579BDF, 32'h2468ACE0, 32'h11223344, 32'h55667788};
        uf = {32'hFEDCBA98, 32'h76543210, 32'h99AABBCC, 32'hDDEEFF00};
        apply_reset();
        m_tready      = 1'b1;
        ts_step       = 32'd2;
        ts_load       = 1'b1;
        ts_load_value = 64'h5000;
        cycle();
        ts_load_value = 64'hFFFF_FFFF_FFFF_FFFF;
        drive({8{32'h00C0FFEE}}, 32'hFFFFFFFF, ue, 1'b1);
        cycle();
        checks++;
        if (m_tvalid !== 1'b1 || m_tuser !== {64'h5000, ue[63:0]}) begin
            failures++;
            $display("FAIL ts_load_preload: got valid=%b user=%h expected 1 %h", m_tvalid,
                     m_tuser, {64'h5000, ue[63:0]});
        end
        ts_load = 1'b0;
        idle();
        cycle();
        drive({8{32'h0BADF00D}}, 32'hFFFFFFFF, uf, 1'b1);
        cycle();
        checks++;
        if (m_tvalid !== 1'b1 || m_tuser !== {64'h1, uf[63:0]}) begin
            failures++;
            $display("FAIL ts_wrap: got valid=%b user=%h expected 1 %h", m_tvalid, m_tuser,
                     {64'h1, uf[63:0]});
        end
        idle();
        cycle();
    endtask

    task automatic test_reset_mid_packet();
        logic [U-1:0] ur, ur2;
        ur  = {32'h0000AAAA, 32'h0000BBBB, 32'h0000CCCC, 32'h0000DDDD};
        ur2 = {32'h4444EEEE, 32'h5555FFFF, 32'h66661111, 32'h77772222};
        apply_reset();
        m_tready = 1'b1;
        ts_step  = 32'd1;
        drive({8{32'h1}}, 32'hFFFFFFFF, '0, 1'b1);
        cycle();
        checks++;
        if (stat_pkt !== 32'd1) begin
            failures++;
            $display("FAIL rmid_pre_count: got %0d expected 1", stat_pkt);
        end
        drive({8{32'h2}}, 32'hFFFFFFFF, '0, 1'b0);
        cycle();
        drive({8{32'h3}}, 32'hFFFFFFFF, '0, 1'b0);
        cycle();
        checks++;
        if (m_tvalid !== 1'b1) begin
            failures++;
            $display("FAIL rmid_pre_valid: got %b expected 1", m_tvalid);
        end
        aresetn = 1'b0;
        idle();
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || out_vec() !== '0 || s_tready !== 1'b0) begin
            failures++;
            $display("FAIL rmid_reset_out: got out=%h tready=%b expected 0/0", out_vec(),
                     s_tready);
        end
        checks++;
        if (stat_pkt !== 32'd0 || stat_byte !== 64'd0) begin
            failures++;
            $display("FAIL rmid_reset_stats: got pkt=%0d bytes=%0d expected 0/0", stat_pkt,
                     stat_byte);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        cycle();
        ts_load       = 1'b1;
        ts_load_value = 64'h77;
        cycle();
        ts_load = 1'b0;
        drive({8{32'h4}}, 32'hFFFFFFFF, ur, 1'b0);
        cycle();
        checks++;
        if (m_tvalid !== 1'b1 || m_tuser !== {64'h77, ur[63:0]}) begin
            failures++;
            $display("FAIL rmid_sop_stamp: got valid=%b user=%h expected 1 %h", m_tvalid,
                     m_tuser, {64'h77, ur[63:0]});
        end
        drive({8{32'h5}}, 32'hFFFFFFFF, ur2, 1'b1);
        cycle();
        checks++;
        if (m_tuser !== ur2 || m_tlast !== 1'b1 || stat_pkt !== 32'd1) begin
            failures++;
            $display("FAIL rmid_mid_beat: got user=%h last=%b pkt=%0d expected %h 1 1", m_tuser,
                     m_tlast, stat_pkt, ur2);
        end
        idle();
        cycle();
    endtask

    task automatic test_random_backpressure();
        localparam int NumPkts = 1000;
        int              sent = 0;
        int              beat_idx = 0;
        int              pkt_len = 1;
        int              cyc = 0;
        logic            accepted = 1'b0;
        logic            prev_stall = 1'b0;
        logic            r;
        logic [OutW-1:0] prev_out;
        logic [OutW-1:0] exp;
        longint unsigned exp_bytes = 0;
        beat_t           e;
        apply_reset();
        ts_step = 32'd3;
        exp_q.delete();
        while ((sent < NumPkts || s_tvalid || exp_q.size() > 0) && cyc < 20000) begin
            @(negedge aclk);
            cyc++;
            if (prev_stall) begin
                checks++;
                if (out_vec() !== prev_out) begin
                    failures++;
                    $display("FAIL rnd_stall_stable: got %h expected %h", out_vec(), prev_out);
                end
            end
            if (cyc % 101 == 0) begin
                r = s_tready;
                m_tready = ~m_tready;
                #1;
                checks++;
                if (s_tready !== r) begin
                    failures++;
                    $display("FAIL rnd_tready_comb: got %b expected %b", s_tready, r);
                end
            end
            m_tready = 1'($urandom_range(0, 1));
            if (m_tvalid && m_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_extra_beat: got %h expected no beat", out_vec());
                end else begin
                    e   = exp_q.pop_front();
                    exp = {1'b1, e.last, e.keep, e.user, e.data};
                    if (out_vec() !== exp) begin
                        failures++;
                        $display("FAIL rnd_beat: got %h expected %h", out_vec(), exp);
                    end
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_out   = out_vec();
            if (accepted) begin
                s_tvalid = 1'b0;
                accepted = 1'b0;
            end
            if (!s_tvalid && sent < NumPkts && $urandom_range(0, 3) != 0) begin
                if (beat_idx == 0) pkt_len = $urandom_range(1, 4);
                for (int i = 0; i < 8; i++) s_tdata[i*32 +: 32] = $urandom;
                for (int i = 0; i < 4; i++) s_tuser[i*32 +: 32] = $urandom;
                s_tkeep  = $urandom;
                s_tlast  = (beat_idx == pkt_len - 1);
                s_tvalid = 1'b1;
            end
            if (s_tvalid && s_tready) begin
                e.data = s_tdata;
                e.keep = s_tkeep;
                e.user = s_tuser;
                e.last = s_tlast;
                if (beat_idx == 0) e.user[64 +: 64] = ts_model;
                exp_q.push_back(e);
                exp_bytes += longint'($countones(s_tkeep));
                accepted = 1'b1;
                if (s_tlast) begin
                    beat_idx = 0;
                    sent++;
                end else begin
                    beat_idx++;
                end
            end
        end
        checks++;
        if (exp_q.size() != 0 || sent != NumPkts) begin
            failures++;
            $display("FAIL rnd_drain: got pending=%0d sent=%0d expected 0/%0d", exp_q.size(),
                     sent, NumPkts);
        end
        checks++;
        if (stat_pkt !== 32'(NumPkts)) begin
            failures++;
            $display("FAIL rnd_pkt_count: got %0d expected %0d", stat_pkt, NumPkts);
        end
        checks++;
        if (stat_byte !== (ByteEn ? 64'(exp_bytes) : 64'd0)) begin
            failures++;
            $display("FAIL rnd_byte_count: got %0d expected %0d", stat_byte,
                     ByteEn ? exp_bytes : 0);
        end
        m_tready = 1'b1;
        idle();
        cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        s_tdata       = '0;
        s_tkeep       = '0;
        s_tuser       = '0;
        s_tlast       = 1'b0;
        s_tvalid      = 1'b0;
        m_tready      = 1'b1;
        ts_step       = 32'd1;
        ts_load       = 1'b0;
        ts_load_value = '0;
        test_reset();
        test_three_beat();
        test_back_to_back();
        test_ts_load();
        test_reset_mid_packet();
        test_random_backpressure();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
